// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
//   enable     : count enable, one step per cycle while high
//   up_down    : direction, 1 = up, 0 = down
//   load       : parallel load strobe (wins over enable)
//   load_value : value to load; clamped to the top of the count range
//   out        : registered count
//   tc         : combinational terminal-count flag
//   wrap       : registered one-cycle wrap-around pulse
// The master modport drives the controls. The slave modport is the counter side.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;

  modport master (
    output enable, up_down, load, load_value,
    input  out, tc, wrap
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output out, tc, wrap
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load. It has a wrap-around mode and
// a saturating mode.
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset; clears the count and the wrap pulse
//   bus   : mod_updown_counter_if.slave with these signals:
//           - enable, up_down, load and load_value come in.
//           - out, tc and wrap go out.
// Parameters:
//   WIDTH    : count register width
//   MODULUS  : count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   SATURATE : 0 = wrap around at the ends, 1 = stick at the ends
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  mod_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   CNT_MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] cnt_p1;
  logic             wrap_p1;
  logic             at_top;
  logic             at_bottom;

  // Loaded values outside the count range pin to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] lv);
    if ({1'b0, lv} >= CNT_MOD) return CNT_MAX;
    return lv;
  endfunction

  // One count step. The result is {wrap_flag, next_count}. At the top and
  // bottom of the range, the step either wraps modulo MODULUS or saturates.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                input logic             up);
    if (up) begin
      if (cur == CNT_MAX)
        return (SATURATE != 0) ? {1'b0, CNT_MAX} : {1'b1, {WIDTH{1'b0}}};
      return {1'b0, cur + WIDTH'(1)};
    end
    if (cur == '0)
      return (SATURATE != 0) ? {1'b0, {WIDTH{1'b0}}} : {1'b1, CNT_MAX};
    return {1'b0, cur - WIDTH'(1)};
  endfunction

  assign at_top    = (cnt_p1 == CNT_MAX);
  assign at_bottom = (cnt_p1 == '0);

  // Terminal count looks at the live direction and enable. A direction change
  // therefore shows up in tc at once.
  assign bus.tc   = bus.enable & ((bus.up_down & at_top) | (~bus.up_down & at_bottom));
  assign bus.out  = cnt_p1;
  assign bus.wrap = wrap_p1;

  // Count register stage: reset > load > count > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1  <= '0;
      wrap_p1 <= 1'b0;
    end else if (bus.load) begin
      cnt_p1  <= clamp_load(bus.load_value);
      wrap_p1 <= 1'b0;
    end else if (bus.enable) begin
      {wrap_p1, cnt_p1} <= step_count(cnt_p1, bus.up_down);
    end else begin
      wrap_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter. It uses three instances:
//   a : MODULUS=10,  wrap-around mode
//   b : MODULUS=10,  saturating mode
//   c : MODULUS=256, wrap-around mode (full binary range)
// Each step drives one instance and checks tc before the edge. It queues the
// expected out/wrap and compares them one time unit after the edge.
module tb_mod_updown_counter;

  logic clk;
  logic rst_a, rst_b, rst_c;

  mod_updown_counter_if #(.WIDTH(8)) bus_a ();
  mod_updown_counter_if #(.WIDTH(8)) bus_b ();
  mod_updown_counter_if #(.WIDTH(8)) bus_c ();

  mod_updown_counter #(.WIDTH(8), .MODULUS(10),  .SATURATE(0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave));
  mod_updown_counter #(.WIDTH(8), .MODULUS(10),  .SATURATE(1)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave));
  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) dut_c (
    .clk(clk), .reset(rst_c), .bus(bus_c.slave));

  typedef struct {
    logic [7:0] out;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_all();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.enable = 1'b0; bus_a.up_down = 1'b1; bus_a.load = 1'b0; bus_a.load_value = '0;
    bus_b.enable = 1'b0; bus_b.up_down = 1'b1; bus_b.load = 1'b0; bus_b.load_value = '0;
    bus_c.enable = 1'b0; bus_c.up_down = 1'b1; bus_c.load = 1'b0; bus_c.load_value = '0;
  endtask

  // Drive one cycle on instance sel. Check tc before the edge when chk_tc is
  // set. Check out and wrap after the edge.
  task automatic step(input int sel, input logic r, input logic en, input logic ud,
                      input logic ld, input logic [7:0] lv, input bit chk_tc,
                      input logic etc, input logic [7:0] eout, input logic ewrap,
                      input string tag);
    exp_t e;
    exp_t got;
    logic tc_now;
    logic [7:0] out_now;
    logic wrap_now;
    idle_all();
    case (sel)
      0: begin rst_a = r; bus_a.enable = en; bus_a.up_down = ud; bus_a.load = ld; bus_a.load_value = lv; end
      1: begin rst_b = r; bus_b.enable = en; bus_b.up_down = ud; bus_b.load = ld; bus_b.load_value = lv; end
      default: begin rst_c = r; bus_c.enable = en; bus_c.up_down = ud; bus_c.load = ld; bus_c.load_value = lv; end
    endcase
    e.out = eout; e.wrap = ewrap; e.tag = tag;
    sbq.push_back(e);
    #1;
    case (sel)
      0: tc_now = bus_a.tc;
      1: tc_now = bus_b.tc;
      default: tc_now = bus_c.tc;
    endcase
    if (chk_tc) check({tag, ".tc"}, {7'b0, tc_now}, {7'b0, etc});
    @(posedge clk);
    #1;
    case (sel)
      0: begin out_now = bus_a.out; wrap_now = bus_a.wrap; end
      1: begin out_now = bus_b.out; wrap_now = bus_b.wrap; end
      default: begin out_now = bus_c.out; wrap_now = bus_c.wrap; end
    endcase
    got = sbq.pop_front();
    check({got.tag, ".out"}, out_now, got.out);
    check({got.tag, ".wrap"}, {7'b0, wrap_now}, {7'b0, got.wrap});
  endtask

  initial begin
    idle_all();
    @(posedge clk);
    #1;

    // ---- instance a: modulo 10, wrap-around ----
    step(0, 1, 0, 1, 0, 8'd0, 0, 0, 8'd0, 0, "a_reset");
    step(0, 1, 1, 0, 0, 8'd0, 1, 1, 8'd0, 0, "a_reset_tc_down");
    step(0, 1, 1, 1, 0, 8'd0, 1, 0, 8'd0, 0, "a_reset_tc_up");
    // Count up 12 cycles: 1..9, 0, 1, 2. Wrap follows 9->0, and tc is high while out is 9.
    for (int i = 0; i < 12; i++)
      step(0, 0, 1, 1, 0, 8'd0, 1, (i == 9), 8'((i + 1) % 10), (i == 9),
           $sformatf("a_up%0d", i));
    // Load 5 with enable, then count down 7: 4,3,2,1,0,9,8.
    step(0, 0, 1, 0, 1, 8'd5, 1, 0, 8'd5, 0, "a_load5");
    begin
      logic [7:0] dn_exp [7] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9, 8'd8};
      for (int i = 0; i < 7; i++)
        step(0, 0, 1, 0, 0, 8'd0, 1, (i == 5), dn_exp[i], (i == 5),
             $sformatf("a_dn%0d", i));
    end
    // Out-of-range loads clamp to 9. A load during tc wins with no wrap.
    step(0, 0, 0, 1, 1, 8'd200, 1, 0, 8'd9, 0, "a_clamp200");
    step(0, 0, 1, 1, 1, 8'd3,   1, 1, 8'd3, 0, "a_load_at_tc");
    step(0, 0, 0, 1, 0, 8'd0,   1, 0, 8'd3, 0, "a_hold_after_load");
    step(0, 0, 0, 1, 1, 8'd10,  1, 0, 8'd9, 0, "a_clamp10");
    // Reset beats load and enable, and then the count holds.
    step(0, 0, 0, 1, 1, 8'd6,   1, 0, 8'd6, 0, "a_load6");
    step(0, 1, 1, 1, 1, 8'd4,   1, 0, 8'd0, 0, "a_reset_vs_load");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, 8'd0, 1, 0, 8'd0, 0, $sformatf("a_hold%0d", i));
    // Reset mid-count restarts counting from 0.
    step(0, 0, 1, 1, 0, 8'd0, 1, 0, 8'd1, 0, "a_mid1");
    step(0, 0, 1, 1, 0, 8'd0, 1, 0, 8'd2, 0, "a_mid2");
    step(0, 1, 1, 1, 0, 8'd0, 1, 0, 8'd0, 0, "a_mid_reset");
    step(0, 0, 1, 1, 0, 8'd0, 1, 0, 8'd1, 0, "a_restart");
    // A direction change takes effect on the same edge.
    step(0, 0, 1, 0, 0, 8'd0, 1, 0, 8'd0, 0, "a_dirdown");
    step(0, 0, 1, 1, 0, 8'd0, 1, 0, 8'd1, 0, "a_dirup");

    // ---- instance b: modulo 10, saturating ----
    step(1, 1, 0, 1, 0, 8'd0, 0, 0, 8'd0, 0, "b_reset");
    step(1, 0, 0, 1, 1, 8'd7, 1, 0, 8'd7, 0, "b_load7");
    begin
      logic [7:0] sat_exp [5] = '{8'd8, 8'd9, 8'd9, 8'd9, 8'd9};
      for (int i = 0; i < 5; i++)
        step(1, 0, 1, 1, 0, 8'd0, 1, (i >= 2), sat_exp[i], 0,
             $sformatf("b_up%0d", i));
    end
    step(1, 0, 0, 0, 1, 8'd1, 1, 0, 8'd1, 0, "b_load1");
    step(1, 0, 1, 0, 0, 8'd0, 1, 0, 8'd0, 0, "b_dn_to0");
    step(1, 0, 1, 0, 0, 8'd0, 1, 1, 8'd0, 0, "b_dn_sat");

    // ---- instance c: modulo 256, natural binary wrap ----
    step(2, 1, 0, 1, 0, 8'd0,   0, 0, 8'd0,   0, "c_reset");
    step(2, 0, 0, 1, 1, 8'd255, 1, 0, 8'd255, 0, "c_load255");
    step(2, 0, 1, 1, 0, 8'd0,   1, 1, 8'd0,   1, "c_up_wrap");
    step(2, 0, 1, 0, 0, 8'd0,   1, 1, 8'd255, 1, "c_dn_wrap");
    step(2, 0, 1, 0, 0, 8'd0,   1, 0, 8'd254, 0, "c_dn");
    step(2, 0, 0, 1, 1, 8'd200, 1, 0, 8'd200, 0, "c_load200");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
